pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central sequencing controller for the 5-stage MIPS pipeline. It drives enable/flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use and RAW hazards, flushes wrong-path instructions on a taken branch/jump resolved in MEM (`PC_sel`), and runs the data-memory request/acknowledge handshake with a timeout. It sits beside the pipeline registers and takes its inputs from their `wb_*`, `data_mem_en` and `PC_sel` fields.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles to wait for `dmem_ack` before abandoning the access (1..255).
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: reset, asynchronous, active-low; clock `clk`.
- `id_rs`, `id_rt` in 5 each: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1 each: the ID instruction actually reads that source.
- `ex_rs`, `ex_rt` in 5 each: source registers of the instruction in EX (forwarding).
- `ex_wb_write_en` in 1, `ex_wb_addr` in 5, `ex_is_load` in 1: destination of the ID/EX instruction.
- `mem_wb_write_en` in 1, `mem_wb_addr` in 5: destination of the EX/MEM instruction.
- `wb_wb_write_en` in 1, `wb_wb_addr` in 5: destination of the MEM/WB instruction.
- `mem_PC_sel` in 1: taken branch/jump in MEM.
- `mem_data_mem_en` in 1: the MEM instruction accesses data memory.
- `dmem_ack` in 1: data memory completed the access.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en` out 1 each: register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1 each: load a bubble (all fields 0) instead of the input.
- `dmem_req` out 1: data memory request.
- `fwd_a_sel`, `fwd_b_sel` out 2 each: ALU operand source. 00 = register file, 01 = EX/MEM `ALU_result`, 10 = MEM/WB write-back data.
- `mem_err` out 1: sticky, set when an access times out.
- `stall_cnt` out 16: saturating count of cycles with `pc_en`=0.

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- Priority, highest first: memory wait, branch flush, data-hazard stall.
- **RUN, memory access.** If `mem_data_mem_en`=1, `dmem_req`=1 in the same cycle.
  - If `dmem_ack`=1 in that cycle, there is zero wait.
  - Otherwise the FSM moves to MEM_WAIT and that cycle is a freeze.
- **MEM_WAIT.** `dmem_req` is held at 1.
  - Freeze: `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=0 and `memwb_flush`=1.
  - The timeout counter increments each cycle.
  - On `dmem_ack`, or when the counter reaches `TIMEOUT_CYCLES`, the pipeline advances that cycle, the FSM returns to RUN and the counter clears.
  - A timeout additionally sets `mem_err`. `mem_err` clears only on reset.
- **Branch.** When `mem_PC_sel`=1 and the pipeline is not frozen, `ifid_flush`=`idex_flush`=`exmem_flush`=1 and all enables stay 1.
  - If the branch instruction also accesses memory, the flush is applied in the ack/timeout cycle.
  - A branch suppresses any data-hazard stall in the same cycle.
- **Source match.** A source matches a stage when all hold: the `uses` bit is set, the addresses are equal, the stage's write enable is 1, and the stage address is not 0.
- **Stall action:** `pc_en`=0, `ifid_en`=0, `idex_flush`=1. EX/MEM and MEM/WB keep advancing.
- **Forwarding** applies only to the EX instruction; register 0 is never forwarded. Per operand:
  - 01 if `mem_wb_write_en` and `mem_wb_addr` equals the operand's source;
  - else 10 if the MEM/WB stage matches;
  - else 00.
- `stall_cnt` increments in every cycle with `pc_en`=0 and saturates at 16'hFFFF.

## Timing
- Enables, flushes, `dmem_req` and `fwd_*` are combinational from the FSM state and the current inputs.
- The FSM state, timeout counter, `mem_err` and `stall_cnt` are registered.
- Reset values (async, immediate):
  - state RUN, counter 0, `mem_err`=0, `stall_cnt`=0.
  - With all inputs 0, the outputs are `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=1, all flushes 0, `dmem_req`=0, `fwd_*`=00.
- A load-use stall lasts exactly 1 cycle with FORWARD_EN.
- Minimum memory freeze is 1 cycle (ack on the cycle after the request). Maximum is `TIMEOUT_CYCLES`.
- Reset asserted in MEM_WAIT aborts the wait immediately. `dmem_req` falls as soon as reset is asserted.

## Configuration
- Macro: `PIPELINE_FORWARD_EN`.
- **Defined:**
  - Stall only when `ex_is_load`=1 and an ID source matches the EX stage.
  - `fwd_*` are driven as described in Operation.
- **Undefined:**
  - Stall whenever an ID source matches the EX, MEM or WB stage (the register file has no write-through).
  - `fwd_a_sel`=`fwd_b_sel`=00 constantly.
  - A dependency costs up to 3 stall cycles.

## Test plan
- **Load-use:** `ex_is_load`=1, `ex_wb_addr`=8, `id_rs`=8, `id_uses_rs`=1 -> exactly one cycle of `pc_en`=0 and `idex_flush`=1; `stall_cnt`=1.
- **Forwarding (FORWARD_EN):** `ex_rs`=9, MEM and WB both write 9 -> `fwd_a_sel`=01. With the MEM write removed -> 10. With `ex_rs`=0 -> 00.
- **Memory wait:** `mem_data_mem_en`=1, `dmem_ack` arrives 3 cycles later -> `dmem_req` high 4 cycles, 3 freeze cycles with `memwb_flush`=1, then advance.
- **Timeout:** `TIMEOUT_CYCLES`=4, no ack -> advance after 4 wait cycles, `mem_err`=1 persists until reset.
- **Branch during load-use:** `mem_PC_sel`=1 while the hazard condition is present -> three flushes asserted, no stall.
- **Reset mid-wait:** reset in MEM_WAIT -> `dmem_req`=0 immediately; after release, state RUN and `stall_cnt`=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencing controller for the 5-stage MIPS pipeline. It produces the
//   load enables and flushes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers. It also resolves data hazards, flushes wrong-path work on a
//   taken branch resolved in MEM, and runs the data-memory req/ack handshake
//   with a timeout.
//   Optional feature macro: PIPELINE_FORWARD_EN.
//     Defined   : ALU operand forwarding is active. Only a load-use stalls.
//     Undefined : forwarding selects are tied to 00. Any dependency on an
//                 in-flight write stalls until that write has retired.

// One ID source against one in-flight destination.
module phc_src_match (
  input  logic [4:0] src,
  input  logic       uses,
  input  logic [4:0] dst,
  input  logic       dst_we,
  output logic       hit
);
  assign hit = uses & dst_we & (dst != 5'd0) & (src == dst);
endmodule

// Forwarding mux select for one EX operand.
// The younger EX/MEM result wins over MEM/WB. r0 is never forwarded.
module phc_fwd_sel (
  input  logic [4:0] src,
  input  logic       mem_we,
  input  logic [4:0] mem_addr,
  input  logic       wb_we,
  input  logic [4:0] wb_addr,
  output logic [1:0] sel
);
  // Pick the youngest matching producer for this operand.
  always_comb begin
    sel = 2'b00;
    if (src != 5'd0) begin
      if (mem_we && (mem_addr == src))     sel = 2'b01;
      else if (wb_we && (wb_addr == src))  sel = 2'b10;
    end
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        ex_wb_write_en,
  input  logic [4:0]  ex_wb_addr,
  input  logic        ex_is_load,
  input  logic        mem_wb_write_en,
  input  logic [4:0]  mem_wb_addr,
  input  logic        wb_wb_write_en,
  input  logic [4:0]  wb_wb_addr,
  input  logic        mem_PC_sel,
  input  logic        mem_data_mem_en,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        dmem_req,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam int NUM_SRC = 2;   // rs, rt
  localparam int NUM_STG = 3;   // EX, MEM, WB producers (index 0 = EX)
  localparam int CNT_W   = 8;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // The counter holds the number of wait cycles already spent.
  // The timeout cycle is therefore the one where it sits at TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctl_t;

  // ------------------------------------------------------------------
  // Source / destination matrices
  // ------------------------------------------------------------------
  logic [NUM_SRC-1:0][4:0]         id_src;
  logic [NUM_SRC-1:0]              id_use;
  logic [NUM_SRC-1:0][4:0]         ex_src;
  logic [NUM_STG-1:0][4:0]         stg_addr;
  logic [NUM_STG-1:0]              stg_we;
  logic [NUM_SRC-1:0][NUM_STG-1:0] hit;
  logic [NUM_SRC-1:0][1:0]         fwd_raw;

  assign id_src   = {id_rt, id_rs};
  assign id_use   = {id_uses_rt, id_uses_rs};
  assign ex_src   = {ex_rt, ex_rs};
  assign stg_addr = {wb_wb_addr, mem_wb_addr, ex_wb_addr};
  assign stg_we   = {wb_wb_write_en, mem_wb_write_en, ex_wb_write_en};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    for (genvar g = 0; g < NUM_STG; g++) begin : g_stg
      phc_src_match u_match (
        .src    (id_src[s]),
        .uses   (id_use[s]),
        .dst    (stg_addr[g]),
        .dst_we (stg_we[g]),
        .hit    (hit[s][g])
      );
    end
    phc_fwd_sel u_fwd (
      .src      (ex_src[s]),
      .mem_we   (mem_wb_write_en),
      .mem_addr (mem_wb_addr),
      .wb_we    (wb_wb_write_en),
      .wb_addr  (wb_wb_addr),
      .sel      (fwd_raw[s])
    );
  end

  // ------------------------------------------------------------------
  // Hazard detection and forwarding (configuration dependent)
  // ------------------------------------------------------------------
  logic hazard;

`ifdef PIPELINE_FORWARD_EN
  // Results from the EX stage onward can be forwarded. Only a load still
  // in EX has no value yet, so that is the one case that must stall.
  logic [NUM_SRC-1:0] ex_hit;
  logic               unused_hits;
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_exhit
    assign ex_hit[s] = hit[s][0];
  end
  assign hazard      = ex_is_load & (|ex_hit);
  assign fwd_a_sel   = fwd_raw[0];
  assign fwd_b_sel   = fwd_raw[1];
  assign unused_hits = ^hit;
`else
  // There is no bypass and no register-file write-through. Any reader of
  // an in-flight destination waits until the write has retired.
  logic unused_fwd;
  assign hazard     = |hit;
  assign fwd_a_sel  = 2'b00;
  assign fwd_b_sel  = 2'b00;
  assign unused_fwd = ^{fwd_raw, ex_is_load};
`endif

  // ------------------------------------------------------------------
  // Memory handshake FSM
  // ------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             freeze;
  logic             req_raw;

  // Next state, wait counter and sticky error. Also decides the freeze.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    freeze    = 1'b0;
    req_raw   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_data_mem_en) begin
          req_raw = 1'b1;
          if (!dmem_ack) begin
            // The request cycle without an ack is already a freeze.
            freeze  = 1'b1;
            state_d = ST_MEM_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_MEM_WAIT: begin
        req_raw = 1'b1;
        if (dmem_ack || (cnt_q == TO_LAST)) begin
          // Release the pipeline this cycle. This covers both an ack and
          // an abandoned access.
          state_d = ST_RUN;
          cnt_d   = '0;
          if (!dmem_ack) mem_err_d = 1'b1;
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Pipeline register controls: memory freeze > branch flush > hazard stall
  // ------------------------------------------------------------------
  ctl_t ctl;

  // Resolve the prioritised enable/flush vector for this cycle.
  always_comb begin
    ctl = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
            default: 1'b0};
    if (freeze) begin
      // Hold everything upstream of MEM and retire a bubble into WB.
      ctl.pc_en       = 1'b0;
      ctl.ifid_en     = 1'b0;
      ctl.idex_en     = 1'b0;
      ctl.exmem_en    = 1'b0;
      ctl.memwb_flush = 1'b1;
    end else if (mem_PC_sel) begin
      // Kill the three younger wrong-path instructions. The PC loads the target.
      ctl.ifid_flush  = 1'b1;
      ctl.idex_flush  = 1'b1;
      ctl.exmem_flush = 1'b1;
    end else if (hazard) begin
      // Hold PC and IF/ID. Inject a bubble into EX. Older stages drain.
      ctl.pc_en      = 1'b0;
      ctl.ifid_en    = 1'b0;
      ctl.idex_flush = 1'b1;
    end
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign idex_en     = ctl.idex_en;
  assign exmem_en    = ctl.exmem_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  assign memwb_flush = ctl.memwb_flush;

  // The request drops with reset itself, without waiting for a clock edge.
  assign dmem_req  = req_raw & reset;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctl.pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (TIMEOUT_CYCLES = 4).
// A behavioural model is checked on every falling edge.
// Directed scenarios add literal expectations.
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_wb_addr, mem_wb_addr, wb_wb_addr;
  logic        id_uses_rs, id_uses_rt, ex_wb_write_en, ex_is_load;
  logic        mem_wb_write_en, wb_wb_write_en, mem_PC_sel, mem_data_mem_en, dmem_ack;
  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req, mem_err;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: waiting for memory, wait cycles spent, error, stall cycles
  bit m_wait   = 1'b0;
  int m_waited = 0;
  bit m_err    = 1'b0;
  int m_stalls = 0;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wb_write_en(ex_wb_write_en), .ex_wb_addr(ex_wb_addr), .ex_is_load(ex_is_load),
    .mem_wb_write_en(mem_wb_write_en), .mem_wb_addr(mem_wb_addr),
    .wb_wb_write_en(wb_wb_write_en), .wb_wb_addr(wb_wb_addr),
    .mem_PC_sel(mem_PC_sel), .mem_data_mem_en(mem_data_mem_en), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .dmem_req(dmem_req),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0;
    ex_wb_write_en = 0; ex_wb_addr = 0; ex_is_load = 0;
    mem_wb_write_en = 0; mem_wb_addr = 0; wb_wb_write_en = 0; wb_wb_addr = 0;
    mem_PC_sel = 0; mem_data_mem_en = 0; dmem_ack = 0;
  endtask

  // Does a reader of src depend on a pending write to dst?
  function automatic bit dep(input logic [4:0] src, input logic u, input logic we,
                             input logic [4:0] dst);
    return u && we && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic bit model_hazard();
    bit on_ex, on_old;
    on_ex  = dep(id_rs, id_uses_rs, ex_wb_write_en, ex_wb_addr) ||
             dep(id_rt, id_uses_rt, ex_wb_write_en, ex_wb_addr);
    on_old = dep(id_rs, id_uses_rs, mem_wb_write_en, mem_wb_addr) ||
             dep(id_rt, id_uses_rt, mem_wb_write_en, mem_wb_addr) ||
             dep(id_rs, id_uses_rs, wb_wb_write_en, wb_wb_addr) ||
             dep(id_rt, id_uses_rt, wb_wb_write_en, wb_wb_addr);
`ifdef PIPELINE_FORWARD_EN
    return ex_is_load && on_ex;
`else
    return on_ex || on_old;
`endif
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef PIPELINE_FORWARD_EN
    if (src == 5'd0) return 2'b00;
    if (mem_wb_write_en && mem_wb_addr == src) return 2'b01;
    if (wb_wb_write_en && wb_wb_addr == src) return 2'b10;
    return 2'b00;
`else
    return (src == 5'd31) ? 2'b00 : 2'b00;
`endif
  endfunction

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin
    bit frozen, stall, req, done_wait;
    logic [8:0] exp_ctl, act_ctl;
    if (chk_en) begin
      if (!reset) begin
        m_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0;
      end
      done_wait = dmem_ack || (m_waited + 1 >= TO);
      frozen    = m_wait ? !done_wait : (mem_data_mem_en && !dmem_ack);
      stall     = !frozen && !mem_PC_sel && model_hazard();
      req       = reset && (m_wait || mem_data_mem_en);
      exp_ctl   = {!(frozen || stall), !(frozen || stall), !frozen, !frozen,
                   !frozen && mem_PC_sel, (!frozen && mem_PC_sel) || stall,
                   !frozen && mem_PC_sel, frozen, req};
      act_ctl   = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
                   exmem_flush, memwb_flush, dmem_req};
      chk("ctl_vector", 32'(act_ctl), 32'(exp_ctl));
      chk("fwd_a_sel", 32'(fwd_a_sel), 32'(model_fwd(ex_rs)));
      chk("fwd_b_sel", 32'(fwd_b_sel), 32'(model_fwd(ex_rt)));
      chk("mem_err", 32'(mem_err), 32'(m_err));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
      if (reset) begin
        if (frozen || stall) m_stalls = (m_stalls >= 65535) ? 65535 : m_stalls + 1;
        if (m_wait) begin
          if (done_wait) begin
            if (!dmem_ack) m_err = 1;
            m_wait = 0; m_waited = 0;
          end else m_waited++;
        end else if (frozen) begin
          m_wait = 1; m_waited = 0;
        end
      end
    end
  end

  initial begin
    int  nreq, nfrz, sc0;
    bit  done;
    clr();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset state
    tick(); tick(); #2;
    chk("rst_pc_en", 32'(pc_en), 1);
    chk("rst_exmem_en", 32'(exmem_en), 1);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_fwd_a", 32'(fwd_a_sel), 0);
    tick(); reset = 1'b1;
    tick();

    // Load-use on rs = r8
    tick(); ex_is_load = 1; ex_wb_write_en = 1; ex_wb_addr = 8; id_rs = 8; id_uses_rs = 1; #2;
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_idex_flush", 32'(idex_flush), 1);
    chk("lu_exmem_en", 32'(exmem_en), 1);
    tick(); ex_is_load = 0; ex_wb_write_en = 0; ex_wb_addr = 0;
    mem_wb_write_en = 1; mem_wb_addr = 8; #2;
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
`ifdef PIPELINE_FORWARD_EN
    chk("lu_released", 32'(pc_en), 1);
`else
    chk("lu_held_on_mem", 32'(pc_en), 0);
`endif
    tick(); clr(); #2;
    chk("lu_resume", 32'(pc_en), 1);

    // Forwarding
    tick(); ex_rs = 9; mem_wb_write_en = 1; mem_wb_addr = 9; wb_wb_write_en = 1; wb_wb_addr = 9; #2;
`ifdef PIPELINE_FORWARD_EN
    chk("fwd_mem", 32'(fwd_a_sel), 1);
    tick(); mem_wb_write_en = 0; #2;
    chk("fwd_wb", 32'(fwd_a_sel), 2);
    tick(); ex_rs = 0; ex_rt = 9; #2;
    chk("fwd_r0", 32'(fwd_a_sel), 0);
    chk("fwd_b_wb", 32'(fwd_b_sel), 2);
`else
    chk("fwd_off_mem", 32'(fwd_a_sel), 0);
    tick(); mem_wb_write_en = 0; #2;
    chk("fwd_off_wb", 32'(fwd_a_sel), 0);
    tick(); ex_rs = 0; ex_rt = 9; #2;
    chk("fwd_off_b", 32'(fwd_b_sel), 0);
`endif
    tick(); clr();

    // Memory wait: ack three cycles after the request
    nreq = 0; nfrz = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); mem_data_mem_en = 1; dmem_ack = (k == 3); #2;
      nreq += int'(dmem_req);
      nfrz += int'(memwb_flush);
    end
    chk("mw_advance", 32'(pc_en), 1);
    tick(); clr(); #2;
    chk("mw_req_cycles", 32'(nreq), 4);
    chk("mw_freeze_cycles", 32'(nfrz), 3);
    chk("mw_req_low", 32'(dmem_req), 0);
    chk("mw_no_err", 32'(mem_err), 0);

    // Timeout with no ack
    nfrz = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick(); mem_data_mem_en = 1; #2;
      if (pc_en) done = 1; else nfrz++;
    end
    chk("to_advanced", 32'(done), 1);
    chk("to_freeze_cycles", 32'(nfrz), TO);
    tick(); clr(); #2;
    chk("to_mem_err", 32'(mem_err), 1);
    repeat (3) tick();
    #2 chk("to_err_sticky", 32'(mem_err), 1);

    // Branch while a load-use hazard is present
    tick(); ex_is_load = 1; ex_wb_write_en = 1; ex_wb_addr = 8; id_rs = 8; id_uses_rs = 1;
    mem_PC_sel = 1; #2;
    sc0 = int'(stall_cnt);
    chk("br_flushes", 32'({ifid_flush, idex_flush, exmem_flush}), 32'h7);
    chk("br_no_stall", 32'({pc_en, ifid_en}), 32'h3);
    tick(); clr(); #2;
    chk("br_stall_cnt", 32'(stall_cnt), 32'(sc0));

    // Branch that also accesses memory: flush waits for the ack
    tick(); mem_PC_sel = 1; mem_data_mem_en = 1; #2;
    chk("brm_frozen", 32'({pc_en, ifid_flush}), 0);
    tick(); dmem_ack = 1; #2;
    chk("brm_flush_on_ack", 32'({pc_en, ifid_flush, idex_flush, exmem_flush}), 32'hF);
    tick(); clr();

    // Reset asserted in MEM_WAIT
    tick(); mem_data_mem_en = 1;
    tick(); tick(); #2;
    chk("rm_waiting", 32'(dmem_req), 1);
    reset = 1'b0; #1;
    chk("rm_req_drop", 32'(dmem_req), 0);
    chk("rm_stall_cnt", 32'(stall_cnt), 0);
    tick(); clr();
    tick(); reset = 1'b1; #2;
    chk("rm_after_req", 32'(dmem_req), 0);
    chk("rm_after_err", 32'(mem_err), 0);
    tick(); tick(); #2;
    chk("rm_run_pc_en", 32'(pc_en), 1);
    chk("rm_after_cnt", 32'(stall_cnt), 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
